// File: rtl/iob_cache_fe_arbiter_pkg.sv
// iob_cache_fe_arbiter_pkg
// Shared constants and types for the cache front-end arbiter.
package iob_cache_fe_arbiter_pkg;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/iob_cache_rr_prio.sv
// iob_cache_rr_prio
// Combinational winner select: round-robin from rr_ptr+1 or lowest index.
module iob_cache_rr_prio
   import iob_cache_fe_arbiter_pkg::*;
#(
   parameter int N_CH     = 2,
   parameter int ARB_MODE = ARB_RR,
   parameter int CH_W     = ch_width(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] rr_ptr,
   output logic            any,
   output logic [CH_W-1:0] idx
);

   logic [CH_W-1:0] cand;

   // Walk from lowest to highest priority so the best candidate is written last
   always_comb begin
      any  = |req;
      idx  = '0;
      cand = '0;
      if (ARB_MODE == ARB_FIXED) begin
         for (int i = N_CH - 1; i >= 0; i--) begin
            cand = CH_W'(i);
            if (req[cand]) idx = cand;
         end
      end else begin
         for (int k = N_CH; k >= 1; k--) begin
            cand = CH_W'((int'(rr_ptr) + k) % N_CH);
            if (req[cand]) idx = cand;
         end
      end
   end

endmodule

// File: rtl/iob_cache_fe_arbiter.sv
// iob_cache_fe_arbiter
// Shares one cache front-end port among N_CH native masters, one access at a time.
module iob_cache_fe_arbiter
   import iob_cache_fe_arbiter_pkg::*;
#(
   parameter int N_CH     = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int ARB_MODE = ARB_RR,
   parameter int CH_W     = ch_width(N_CH)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_CH-1:0]            m_valid,
   input  logic [N_CH*ADDR_W-1:0]     m_addr,
   input  logic [N_CH*DATA_W-1:0]     m_wdata,
   input  logic [N_CH*(DATA_W/8)-1:0] m_wstrb,
   output logic [DATA_W-1:0]          m_rdata,
   output logic [N_CH-1:0]            m_ready,
   output logic                       s_valid,
   output logic [ADDR_W-1:0]          s_addr,
   output logic [DATA_W-1:0]          s_wdata,
   output logic [DATA_W/8-1:0]        s_wstrb,
   input  logic [DATA_W-1:0]          s_rdata,
   input  logic                       s_ready,
   output logic                       busy,
   output logic [CH_W-1:0]            grant
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic [CH_W-1:0]   grant_q, grant_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic              req_any;
   logic [CH_W-1:0]   req_idx;

   iob_cache_rr_prio #(
      .N_CH     (N_CH),
      .ARB_MODE (ARB_MODE),
      .CH_W     (CH_W)
   ) u_prio (
      .req    (m_valid),
      .rr_ptr (rr_ptr_q),
      .any    (req_any),
      .idx    (req_idx)
   );

   // Arbitrate in IDLE, capture the winner, route completion back in BUSY
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      m_ready  = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               state_d = ST_BUSY;
               grant_d = req_idx;
               addr_d  = m_addr[int'(req_idx)*ADDR_W +: ADDR_W];
               wdata_d = m_wdata[int'(req_idx)*DATA_W +: DATA_W];
               wstrb_d = m_wstrb[int'(req_idx)*STRB_W +: STRB_W];
            end
         end
         ST_BUSY: begin
            if (s_ready) begin
               m_ready[grant_q] = 1'b1;
               state_d          = ST_IDLE;
               if (ARB_MODE == ARB_RR) rr_ptr_d = grant_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and request registers; rr_ptr restarts so channel 0 goes first
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         grant_q  <= '0;
         rr_ptr_q <= CH_W'(N_CH - 1);
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign s_valid = (state_q == ST_BUSY);
   assign busy    = (state_q == ST_BUSY);
   assign s_addr  = addr_q;
   assign s_wdata = wdata_q;
   assign s_wstrb = wstrb_q;
   assign grant   = grant_q;
   assign m_rdata = s_rdata;

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
// tb_iob_cache_fe_arbiter
// Vector table plus scoreboarded sequences for RR (3 ch) and fixed (4 ch) arbiters.
module tb_iob_cache_fe_arbiter;

   logic        clk = 1'b0;
   logic        reset;

   logic [2:0]  m_valid;
   logic [95:0] m_addr;
   logic [95:0] m_wdata;
   logic [11:0] m_wstrb;
   logic [31:0] m_rdata;
   logic [2:0]  m_ready;
   logic        s_valid;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic [31:0] s_rdata;
   logic        s_ready;
   logic        busy;
   logic [1:0]  grant;

   logic [3:0]   f_m_valid;
   logic [127:0] f_m_addr;
   logic [127:0] f_m_wdata;
   logic [15:0]  f_m_wstrb;
   logic [31:0]  f_m_rdata;
   logic [3:0]   f_m_ready;
   logic         f_s_valid;
   logic [31:0]  f_s_addr;
   logic [31:0]  f_s_wdata;
   logic [3:0]   f_s_wstrb;
   logic [31:0]  f_s_rdata;
   logic         f_s_ready;
   logic         f_busy;
   logic [1:0]   f_grant;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          ch;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          lat;
      logic [31:0] rdata;
      logic [1:0]  exp_g;
      logic [2:0]  exp_rdy;
   } vec_t;

   typedef struct {
      logic [1:0]  g;
      logic [2:0]  rdy;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } exp_t;

   vec_t vecs[6];
   exp_t sb[$];

   iob_cache_fe_arbiter #(
      .N_CH(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)
   ) u_rr (
      .clk(clk), .reset(reset),
      .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready),
      .busy(busy), .grant(grant)
   );

   iob_cache_fe_arbiter #(
      .N_CH(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)
   ) u_fx (
      .clk(clk), .reset(reset),
      .m_valid(f_m_valid), .m_addr(f_m_addr), .m_wdata(f_m_wdata),
      .m_wstrb(f_m_wstrb), .m_rdata(f_m_rdata), .m_ready(f_m_ready),
      .s_valid(f_s_valid), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
      .s_wstrb(f_s_wstrb), .s_rdata(f_s_rdata), .s_ready(f_s_ready),
      .busy(f_busy), .grant(f_grant)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] g, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] ws);
      exp_t e;
      logic [2:0] one;
      one     = 3'b001;
      e.g     = g;
      e.rdy   = one << g;
      e.addr  = a;
      e.wdata = wd;
      e.wstrb = ws;
      return e;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Slave side of one transaction: wait grant, pop expectation, stall, complete
   task automatic serve(input int lat, input logic [31:0] rd, input bit drop,
                        input bit chk_lat, input bit scr);
      exp_t e;
      int n;
      n = 0;
      @(negedge clk);
      while (!s_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!s_valid) begin
         chk("grant_timeout", 0, 1);
         return;
      end
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      if (chk_lat) chk("grant_latency", n, 0);
      chk("grant", grant, e.g);
      chk("s_addr", s_addr, e.addr);
      chk("s_wdata", s_wdata, e.wdata);
      chk("s_wstrb", s_wstrb, e.wstrb);
      chk("busy", busy, 1);
      for (int k = 0; k < lat; k++) begin
         if (scr) begin
            m_addr  = {$urandom, $urandom, $urandom};
            m_wdata = {$urandom, $urandom, $urandom};
            m_wstrb = 12'($urandom);
         end
         @(negedge clk);
         chk("stall_hold", {s_valid, s_addr, s_wdata, s_wstrb},
             {1'b1, e.addr, e.wdata, e.wstrb});
         chk("stall_no_ready", m_ready, 0);
      end
      s_rdata = rd;
      s_ready = 1'b1;
      #1;
      chk("m_ready", m_ready, e.rdy);
      chk("m_rdata", m_rdata, rd);
      @(negedge clk);
      s_ready = 1'b0;
      if (drop) m_valid[e.g] = 1'b0;
      chk("done_idle", {s_valid, busy}, 0);
      chk("grant_hold", grant, e.g);
   endtask

   initial begin
      int n;
      vecs[0] = '{ch:0, addr:32'h100, wdata:32'h0, wstrb:4'h0, lat:3,
                  rdata:32'hDEADBEEF, exp_g:2'd0, exp_rdy:3'b001};
      vecs[1] = '{ch:1, addr:32'h40, wdata:32'h12345678, wstrb:4'b0011,
                  lat:5, rdata:32'h0, exp_g:2'd1, exp_rdy:3'b010};
      vecs[2] = '{ch:2, addr:32'hFFFFFFFC, wdata:32'hA5A5A5A5,
                  wstrb:4'hF, lat:0, rdata:32'h0, exp_g:2'd2,
                  exp_rdy:3'b100};
      vecs[3] = '{ch:0, addr:32'h0, wdata:32'h0, wstrb:4'h0, lat:1,
                  rdata:32'hFFFFFFFF, exp_g:2'd0, exp_rdy:3'b001};
      vecs[4] = '{ch:2, addr:32'h2468, wdata:32'h0, wstrb:4'h0, lat:2,
                  rdata:32'h13579BDF, exp_g:2'd2, exp_rdy:3'b100};
      vecs[5] = '{ch:1, addr:32'h8000_0010, wdata:32'hCAFEF00D,
                  wstrb:4'b1000, lat:4, rdata:32'h0, exp_g:2'd1,
                  exp_rdy:3'b010};

      reset     = 1'b1;
      m_valid   = '0;
      m_addr    = '0;
      m_wdata   = '0;
      m_wstrb   = '0;
      s_rdata   = '0;
      s_ready   = 1'b0;
      f_m_valid = '0;
      f_m_addr  = '0;
      f_m_wdata = '0;
      f_m_wstrb = '0;
      f_s_rdata = '0;
      f_s_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_valid", s_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_m_ready", m_ready, 0);
      chk("rst_s_bus", {s_addr, s_wdata, s_wstrb}, 0);
      chk("rst_fx", {f_s_valid, f_busy, f_grant, f_m_ready}, 0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         m_addr[vecs[i].ch*32 +: 32]  = vecs[i].addr;
         m_wdata[vecs[i].ch*32 +: 32] = vecs[i].wdata;
         m_wstrb[vecs[i].ch*4 +: 4]   = vecs[i].wstrb;
         m_valid[vecs[i].ch]          = 1'b1;
         sb.push_back('{vecs[i].exp_g, vecs[i].exp_rdy, vecs[i].addr,
                        vecs[i].wdata, vecs[i].wstrb});
         serve(vecs[i].lat, vecs[i].rdata, 1'b1, 1'b1, 1'b1);
      end

      s_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("idle_s_ready", {s_valid, busy, m_ready}, 0);
      end
      s_ready = 1'b0;

      m_addr  = '0;
      m_wdata = '0;
      m_wstrb = '0;
      do_reset();
      m_addr[0 +: 32]  = 32'hA0;
      m_addr[32 +: 32] = 32'hB0;
      m_valid          = 3'b011;
      sb.push_back(mk(2'd0, 32'hA0, 32'h0, 4'h0));
      sb.push_back(mk(2'd1, 32'hB0, 32'h0, 4'h0));
      serve(2, 32'h11, 1'b0, 1'b1, 1'b0);
      m_addr[0 +: 32] = 32'hA4;
      sb.push_back(mk(2'd0, 32'hA4, 32'h0, 4'h0));
      serve(1, 32'h22, 1'b1, 1'b1, 1'b0);
      serve(1, 32'h33, 1'b1, 1'b0, 1'b0);

      m_addr[32 +: 32] = 32'hC0;
      m_valid          = 3'b010;
      @(negedge clk);
      chk("rb_grant", {s_valid, grant}, {1'b1, 2'd1});
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b1;
      s_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("rb_after", {s_valid, busy, m_ready, grant}, 0);
      reset   = 1'b0;
      s_ready = 1'b0;
      m_addr[0 +: 32] = 32'hD0;
      m_valid         = 3'b011;
      sb.push_back(mk(2'd0, 32'hD0, 32'h0, 4'h0));
      sb.push_back(mk(2'd1, 32'hC0, 32'h0, 4'h0));
      serve(1, 32'h44, 1'b1, 1'b1, 1'b0);
      serve(1, 32'h55, 1'b1, 1'b0, 1'b0);

      do_reset();
      m_addr  = {32'h30, 32'h20, 32'h10};
      m_valid = 3'b111;
      for (int i = 0; i < 9; i++) begin
         sb.push_back(mk(2'(i % 3), 32'h10 * (i % 3 + 1), 32'h0, 4'h0));
      end
      for (int i = 0; i < 9; i++) begin
         serve(i % 3, 32'h100 + i, 1'b0, 1'b0, 1'b0);
      end
      m_valid = '0;
      chk("sb_drained", sb.size(), 0);

      f_m_addr[32 +: 32] = 32'h1000;
      f_m_addr[96 +: 32] = 32'h3000;
      f_m_valid          = 4'b1010;
      for (int t = 0; t < 4; t++) begin
         n = 0;
         @(negedge clk);
         while (!f_s_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("fx_grant", {f_s_valid, f_grant}, {1'b1, 2'd1});
         chk("fx_addr", f_s_addr, 32'h1000);
         f_s_rdata = 32'(t);
         f_s_ready = 1'b1;
         #1;
         chk("fx_ready", f_m_ready, 4'b0010);
         @(negedge clk);
         f_s_ready = 1'b0;
      end
      f_m_valid = 4'b1000;
      n = 0;
      @(negedge clk);
      while (!f_s_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("fx_ch3_grant", {f_s_valid, f_grant, f_s_addr},
          {1'b1, 2'd3, 32'h3000});
      f_s_ready = 1'b1;
      #1;
      chk("fx_ch3_ready", f_m_ready, 4'b1000);
      @(negedge clk);
      f_s_ready = 1'b0;
      f_m_valid = '0;
      @(negedge clk);
      chk("fx_idle", {f_s_valid, f_busy}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
